lane_word_packer: RTL

Packs a stream of DATA_WIDTH-bit lane items, arriving one per cycle on a valid/ready handshake, into NUM_LANES-wide words. Lane i of each word occupies bits [i*DATA_WIDTH +: DATA_WIDTH]. The block sits directly upstream of the per-lane result register bank: it turns serial unit results into one packed 32-bit result word per group, and marks which lanes are valid. A registered output stage holds one word and supports back-to-back streaming at one item per cycle.

---
 rtl/lane_word_packer.sv | 87 ++++++++
 1 files changed

// File: rtl/lane_word_packer.sv
// Packs a stream of DATA_WIDTH-bit lane items into NUM_LANES-wide words,
// with early close (in_last), a lane-valid mask and a registered output stage.
module lane_word_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LANES  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH*NUM_LANES-1:0] out_data,
    output logic [NUM_LANES-1:0]            out_lane_mask,
    output logic                            out_last,
    output logic [15:0]                     word_count
);

    localparam int W     = DATA_WIDTH * NUM_LANES;
    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

    logic [IDX_W-1:0]     idx;
    logic [W-1:0]         asm_data;
    logic [NUM_LANES-1:0] asm_mask;
    logic [W-1:0]         merged_data;
    logic [NUM_LANES-1:0] merged_mask;
    logic                 accept;
    logic                 handoff;
    logic                 complete;

    // Valid/ready: a transfer happens on a side exactly when valid && ready are
    // both high at a rising edge; the sender holds data stable until then, and
    // in_ready depends only on the output register, never on in_valid.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid && out_ready;
    assign complete = accept && ((idx == LAST_IDX) || in_last);

    // Current assembly with the incoming item dropped into lane idx.
    always_comb begin
        merged_data = asm_data;
        merged_data[int'(idx)*DATA_WIDTH +: DATA_WIDTH] = in_data;
        merged_mask = asm_mask;
        merged_mask[idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx           <= '0;
            asm_data      <= '0;
            asm_mask      <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_lane_mask <= '0;
            out_last      <= 1'b0;
            word_count    <= '0;
        end else begin
            if (handoff) begin
                word_count <= word_count + 16'd1;
            end
            if (complete) begin
                // A completion may coincide with a handoff: the new word
                // replaces the departing one and out_valid stays high.
                out_data      <= merged_data;
                out_lane_mask <= merged_mask;
                out_last      <= in_last;
                out_valid     <= 1'b1;
                asm_data      <= '0;
                asm_mask      <= '0;
                idx           <= '0;
            end else begin
                if (handoff) begin
                    out_valid <= 1'b0;
                end
                if (accept) begin
                    asm_data <= merged_data;
                    asm_mask <= merged_mask;
                    idx      <= idx + 1'b1;
                end
            end
        end
    end

endmodule
